// File: rtl/axi_mem_window_pkg.sv
// Shared types and constants for the AXI4 memory-window stage.
// Holds the write/read FSM state encodings, the AXI response codes, and the
// window-end computation used by the range checker.
package axi_mem_window_pkg;

    typedef enum logic [2:0] {
        W_IDLE,
        W_FWD,
        W_RESP,
        W_SINK,
        W_ERR
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FWD,
        R_ERR
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // One-past-the-end of the window, kept one bit wider than any address so
    // a window ending exactly at the top of the address space still fits.
    function automatic logic [64:0] win_end(input logic [63:0] base, input logic [63:0] size);
        return {1'b0, base} + {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_mem_window_chk.sv
// Combinational burst range check and address relocation.
// A burst hits when its first and last byte both fall inside the window;
// hits are relocated so that WIN_BASE maps onto DST_BASE.
module axi_mem_window_chk
    import axi_mem_window_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] WIN_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] WIN_SIZE = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] DST_BASE = 32'h1000_0000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    output logic              hit,
    output logic [ADDR_W-1:0] maddr
);

    localparam logic [ADDR_W:0] WIN_END = (ADDR_W+1)'(win_end(64'(WIN_BASE), 64'(WIN_SIZE)));

    logic [ADDR_W:0] nbytes;
    logic [ADDR_W:0] last;

    // Burst footprint, last byte address, window test and relocation.
    always_comb begin
        nbytes = ((ADDR_W+1)'(len) + (ADDR_W+1)'(1)) << size;
        last   = {1'b0, addr} + nbytes - (ADDR_W+1)'(1);
        hit    = (addr >= WIN_BASE) && (last < WIN_END) && !last[ADDR_W];
        maddr  = addr - WIN_BASE + DST_BASE;
    end

endmodule

// File: rtl/axi_mem_window.sv
// AXI4 memory-window stage between the core master and the PS slave port.
// In-window bursts are relocated and forwarded; out-of-window bursts are
// absorbed locally and answered with DECERR. One transaction per direction.
// Optional feature: define AXI_MEM_WINDOW_ERRCNT_EN to add err_cnt/err_addr.
module axi_mem_window
    import axi_mem_window_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 64,
    parameter int                ID_W     = 1,
    parameter logic [ADDR_W-1:0] WIN_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] WIN_SIZE = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] DST_BASE = 32'h1000_0000
) (
    input  logic                  uncoreclk,
    input  logic                  uncore_rstn,
    // core side
    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_W-1:0]       s_axi_arid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_W-1:0]       s_axi_rid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // PS side
    output logic [ID_W-1:0]       m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_W-1:0]       m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_W-1:0]       m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_W-1:0]       m_axi_rid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
`ifdef AXI_MEM_WINDOW_ERRCNT_EN
    ,
    output logic [15:0]           err_cnt,
    output logic [ADDR_W-1:0]     err_addr
`endif
);

    wr_state_t         wr_state, wr_next;
    rd_state_t         rd_state, rd_next;
    logic              aw_hit, ar_hit;
    logic [ADDR_W-1:0] aw_maddr, ar_maddr;
    logic              aw_fire, ar_fire;
    logic              b_done, r_done;
    logic [ID_W-1:0]   bid_q, rid_q;
    logic [7:0]        err_beats;

    axi_mem_window_chk #(
        .ADDR_W(ADDR_W), .WIN_BASE(WIN_BASE), .WIN_SIZE(WIN_SIZE), .DST_BASE(DST_BASE)
    ) u_aw_chk (
        .addr(s_axi_awaddr), .len(s_axi_awlen), .size(s_axi_awsize),
        .hit(aw_hit), .maddr(aw_maddr)
    );

    axi_mem_window_chk #(
        .ADDR_W(ADDR_W), .WIN_BASE(WIN_BASE), .WIN_SIZE(WIN_SIZE), .DST_BASE(DST_BASE)
    ) u_ar_chk (
        .addr(s_axi_araddr), .len(s_axi_arlen), .size(s_axi_arsize),
        .hit(ar_hit), .maddr(ar_maddr)
    );

    assign aw_fire = s_axi_awvalid && (wr_state == W_IDLE);
    assign ar_fire = s_axi_arvalid && (rd_state == R_IDLE);

    // W payload is wired straight through; only valid/ready are gated.
    assign m_axi_wdata = s_axi_wdata;
    assign m_axi_wstrb = s_axi_wstrb;
    assign m_axi_wlast = s_axi_wlast;

    // ---------------- write path ----------------

    // Write FSM state register.
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) wr_state <= W_IDLE;
        else              wr_state <= wr_next;
    end

    // Write next-state and channel gating.
    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bid     = '0;
        s_axi_bresp   = AXI_RESP_OKAY;
        m_axi_bready  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) wr_next = aw_hit ? W_FWD : W_SINK;
            end
            W_FWD: begin
                m_axi_wvalid = s_axi_wvalid;
                s_axi_wready = m_axi_wready;
                if (s_axi_wvalid && m_axi_wready && s_axi_wlast) wr_next = W_RESP;
            end
            W_RESP: begin
                // Once B has been handed over, hold off any further B until AW completes.
                s_axi_bvalid = m_axi_bvalid && !b_done;
                m_axi_bready = s_axi_bready && !b_done;
                s_axi_bid    = m_axi_bid;
                s_axi_bresp  = m_axi_bresp;
                if ((b_done || (m_axi_bvalid && s_axi_bready)) && (!m_axi_awvalid || m_axi_awready))
                    wr_next = W_IDLE;
            end
            W_SINK: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) wr_next = W_ERR;
            end
            W_ERR: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = bid_q;
                s_axi_bresp  = AXI_RESP_DECERR;
                if (s_axi_bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // AW valid and B-completed flag (control, reset).
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            m_axi_awvalid <= 1'b0;
            b_done        <= 1'b0;
        end else begin
            if (aw_fire && aw_hit)  m_axi_awvalid <= 1'b1;
            else if (m_axi_awready) m_axi_awvalid <= 1'b0;
            b_done <= (wr_state == W_RESP) && (wr_next == W_RESP)
                      && (b_done || (m_axi_bvalid && m_axi_bready));
        end
    end

    // AW payload capture (data, not reset).
    always_ff @(posedge uncoreclk) begin
        if (aw_fire) begin
            m_axi_awid    <= s_axi_awid;
            m_axi_awaddr  <= aw_maddr;
            m_axi_awlen   <= s_axi_awlen;
            m_axi_awsize  <= s_axi_awsize;
            m_axi_awburst <= s_axi_awburst;
            bid_q         <= s_axi_awid;
        end
    end

    // ---------------- read path ----------------

    // Read FSM state register.
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) rd_state <= R_IDLE;
        else              rd_state <= rd_next;
    end

    // Read next-state and channel gating.
    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rid     = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = AXI_RESP_OKAY;
        s_axi_rlast   = 1'b0;
        m_axi_rready  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) rd_next = ar_hit ? R_FWD : R_ERR;
            end
            R_FWD: begin
                s_axi_rvalid = m_axi_rvalid && !r_done;
                m_axi_rready = s_axi_rready && !r_done;
                s_axi_rid    = m_axi_rid;
                s_axi_rdata  = m_axi_rdata;
                s_axi_rresp  = m_axi_rresp;
                s_axi_rlast  = m_axi_rlast;
                if ((r_done || (m_axi_rvalid && s_axi_rready && m_axi_rlast))
                    && (!m_axi_arvalid || m_axi_arready))
                    rd_next = R_IDLE;
            end
            R_ERR: begin
                s_axi_rvalid = 1'b1;
                s_axi_rid    = rid_q;
                s_axi_rresp  = AXI_RESP_DECERR;
                s_axi_rlast  = (err_beats == 8'd0);
                if (s_axi_rready && (err_beats == 8'd0)) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // AR valid, R-completed flag and DECERR beat counter (control, reset).
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            m_axi_arvalid <= 1'b0;
            r_done        <= 1'b0;
            err_beats     <= 8'd0;
        end else begin
            if (ar_fire && ar_hit)  m_axi_arvalid <= 1'b1;
            else if (m_axi_arready) m_axi_arvalid <= 1'b0;
            r_done <= (rd_state == R_FWD) && (rd_next == R_FWD)
                      && (r_done || (m_axi_rvalid && m_axi_rready && m_axi_rlast));
            if (ar_fire && !ar_hit)
                err_beats <= s_axi_arlen;
            else if ((rd_state == R_ERR) && s_axi_rready && (err_beats != 8'd0))
                err_beats <= err_beats - 8'd1;
        end
    end

    // AR payload capture (data, not reset).
    always_ff @(posedge uncoreclk) begin
        if (ar_fire) begin
            m_axi_arid    <= s_axi_arid;
            m_axi_araddr  <= ar_maddr;
            m_axi_arlen   <= s_axi_arlen;
            m_axi_arsize  <= s_axi_arsize;
            m_axi_arburst <= s_axi_arburst;
            rid_q         <= s_axi_arid;
        end
    end

`ifdef AXI_MEM_WINDOW_ERRCNT_EN
    logic aw_rej, ar_rej;
    assign aw_rej = aw_fire && !aw_hit;
    assign ar_rej = ar_fire && !ar_hit;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Saturating reject counter; both channels may reject in one cycle.
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn)
            err_cnt <= 16'd0;
        else if (aw_rej || ar_rej)
            err_cnt <= sat_add(err_cnt, {1'b0, aw_rej} + {1'b0, ar_rej});
    end

    // Most recent rejected address; AR wins a same-cycle tie.
    always_ff @(posedge uncoreclk) begin
        if (ar_rej)      err_addr <= s_axi_araddr;
        else if (aw_rej) err_addr <= s_axi_awaddr;
    end
`endif

endmodule

// File: tb/tb_axi_mem_window.sv
// Directed bench for axi_mem_window: a vector table of bursts (hit/miss,
// read/write, window edges) plus hand-written simultaneous, reset and
// error-counter sequences.
module tb_axi_mem_window;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 1;

    logic uncoreclk = 1'b0;
    logic uncore_rstn = 1'b1;
    always #5 uncoreclk = ~uncoreclk;

    logic [ID_W-1:0] s_axi_awid = '0;  logic [ADDR_W-1:0] s_axi_awaddr = '0;
    logic [7:0] s_axi_awlen = '0;      logic [2:0] s_axi_awsize = '0;
    logic [1:0] s_axi_awburst = '0;    logic s_axi_awvalid = 1'b0;  logic s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata = '0; logic [DATA_W/8-1:0] s_axi_wstrb = '0;
    logic s_axi_wlast = 1'b0;          logic s_axi_wvalid = 1'b0;   logic s_axi_wready;
    logic [ID_W-1:0] s_axi_bid;        logic [1:0] s_axi_bresp;     logic s_axi_bvalid;
    logic s_axi_bready = 1'b0;
    logic [ID_W-1:0] s_axi_arid = '0;  logic [ADDR_W-1:0] s_axi_araddr = '0;
    logic [7:0] s_axi_arlen = '0;      logic [2:0] s_axi_arsize = '0;
    logic [1:0] s_axi_arburst = '0;    logic s_axi_arvalid = 1'b0;  logic s_axi_arready;
    logic [ID_W-1:0] s_axi_rid;        logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0] s_axi_rresp;           logic s_axi_rlast;           logic s_axi_rvalid;
    logic s_axi_rready = 1'b0;

    logic [ID_W-1:0] m_axi_awid;       logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0] m_axi_awlen;           logic [2:0] m_axi_awsize;
    logic [1:0] m_axi_awburst;         logic m_axi_awvalid;         logic m_axi_awready = 1'b0;
    logic [DATA_W-1:0] m_axi_wdata;    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic m_axi_wlast;                 logic m_axi_wvalid;          logic m_axi_wready = 1'b0;
    logic [ID_W-1:0] m_axi_bid = '0;   logic [1:0] m_axi_bresp = '0;
    logic m_axi_bvalid = 1'b0;         logic m_axi_bready;
    logic [ID_W-1:0] m_axi_arid;       logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0] m_axi_arlen;           logic [2:0] m_axi_arsize;
    logic [1:0] m_axi_arburst;         logic m_axi_arvalid;         logic m_axi_arready = 1'b0;
    logic [ID_W-1:0] m_axi_rid = '0;   logic [DATA_W-1:0] m_axi_rdata = '0;
    logic [1:0] m_axi_rresp = '0;      logic m_axi_rlast = 1'b0;
    logic m_axi_rvalid = 1'b0;         logic m_axi_rready;
`ifdef AXI_MEM_WINDOW_ERRCNT_EN
    logic [15:0] err_cnt;
    logic [ADDR_W-1:0] err_addr;
`endif

    axi_mem_window dut (
        .uncoreclk(uncoreclk), .uncore_rstn(uncore_rstn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef AXI_MEM_WINDOW_ERRCNT_EN
        , .err_cnt(err_cnt), .err_addr(err_addr)
`endif
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        rnd;    // randomise rready on DECERR reads
        int          delay;  // extra cycles m_awready stays low after the W beats
        logic        hit;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs[11];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_read(input vec_t v, input logic [ID_W-1:0] id);
        int beats;
        int tries;
        logic [63:0] pat;
        beats = int'(v.len) + 1;
        @(negedge uncoreclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = v.addr; s_axi_arlen = v.len;
        s_axi_arsize = v.size; s_axi_arburst = 2'b01; s_axi_arid = id;
        #1 check("arready_idle", s_axi_arready, 1'b1);
        @(negedge uncoreclk);
        s_axi_arvalid = 1'b0;
        #1;
        if (v.hit) begin
            check("m_arvalid", m_axi_arvalid, 1'b1);
            check("m_araddr", m_axi_araddr, v.maddr);
            check("m_arlen", m_axi_arlen, v.len);
            check("m_arid", m_axi_arid, id);
            m_axi_arready = 1'b1;
            @(negedge uncoreclk);
            m_axi_arready = 1'b0;
            #1 check("m_arvalid_drop", m_axi_arvalid, 1'b0);
            for (int i = 0; i < beats; i++) begin
                pat = {24'hD0D0D0, 8'(i), v.addr};
                m_axi_rvalid = 1'b1; m_axi_rdata = pat; m_axi_rlast = (i == beats - 1);
                m_axi_rresp = 2'b00; m_axi_rid = id; s_axi_rready = 1'b1;
                #1;
                check("fwd_rvalid", s_axi_rvalid, 1'b1);
                check("fwd_rdata", s_axi_rdata, pat);
                check("fwd_rlast", s_axi_rlast, (i == beats - 1));
                check("fwd_rresp", s_axi_rresp, 2'b00);
                check("fwd_m_rready", m_axi_rready, 1'b1);
                @(negedge uncoreclk);
            end
            m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready = 1'b0;
            #1 check("rd_back_idle", s_axi_arready, 1'b1);
        end else begin
            check("miss_no_m_arvalid", m_axi_arvalid, 1'b0);
            for (int i = 0; i < beats; i++) begin
                tries = 0;
                forever begin
                    s_axi_rready = (!v.rnd || tries >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                    #1;
                    check("err_rvalid", s_axi_rvalid, 1'b1);
                    check("err_rresp", s_axi_rresp, 2'b11);
                    check("err_rdata", s_axi_rdata, 64'd0);
                    check("err_rlast", s_axi_rlast, (i == beats - 1));
                    check("err_rid", s_axi_rid, id);
                    check("err_m_arvalid", m_axi_arvalid, 1'b0);
                    @(negedge uncoreclk);
                    if (s_axi_rready) break;
                    tries++;
                end
            end
            s_axi_rready = 1'b0;
            #1;
            check("err_rvalid_end", s_axi_rvalid, 1'b0);
            check("err_back_idle", s_axi_arready, 1'b1);
        end
    endtask

    task automatic do_write(input vec_t v, input logic [ID_W-1:0] id);
        int beats;
        logic [63:0] pat;
        beats = int'(v.len) + 1;
        @(negedge uncoreclk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = v.addr; s_axi_awlen = v.len;
        s_axi_awsize = v.size; s_axi_awburst = 2'b01; s_axi_awid = id;
        #1 check("awready_idle", s_axi_awready, 1'b1);
        @(negedge uncoreclk);
        s_axi_awvalid = 1'b0;
        #1;
        if (v.hit) begin
            check("m_awvalid", m_axi_awvalid, 1'b1);
            check("m_awaddr", m_axi_awaddr, v.maddr);
            check("m_awlen", m_axi_awlen, v.len);
            check("m_awid", m_axi_awid, id);
            m_axi_awready = 1'b0; m_axi_wready = 1'b1;
            for (int i = 0; i < beats; i++) begin
                pat = {24'hA5A5A5, 8'(i), v.addr};
                s_axi_wvalid = 1'b1; s_axi_wdata = pat; s_axi_wstrb = 8'hF0 ^ 8'(i);
                s_axi_wlast = (i == beats - 1);
                #1;
                check("fwd_m_wvalid", m_axi_wvalid, 1'b1);
                check("fwd_wdata", m_axi_wdata, pat);
                check("fwd_wstrb", m_axi_wstrb, 8'hF0 ^ 8'(i));
                check("fwd_wlast", m_axi_wlast, (i == beats - 1));
                check("fwd_s_wready", s_axi_wready, 1'b1);
                check("fwd_awready_busy", s_axi_awready, 1'b0);
                check("fwd_m_awvalid_held", m_axi_awvalid, 1'b1);
                @(negedge uncoreclk);
            end
            s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; m_axi_wready = 1'b0;
            repeat (v.delay) begin
                #1;
                check("aw_wait_m_awvalid", m_axi_awvalid, 1'b1);
                check("aw_wait_awready", s_axi_awready, 1'b0);
                @(negedge uncoreclk);
            end
            m_axi_awready = 1'b1;
            @(negedge uncoreclk);
            m_axi_awready = 1'b0;
            #1;
            check("m_awvalid_drop", m_axi_awvalid, 1'b0);
            check("resp_awready_busy", s_axi_awready, 1'b0);
            m_axi_bvalid = 1'b1; m_axi_bid = id; m_axi_bresp = 2'b00; s_axi_bready = 1'b1;
            #1;
            check("fwd_bvalid", s_axi_bvalid, 1'b1);
            check("fwd_bresp", s_axi_bresp, 2'b00);
            check("fwd_bid", s_axi_bid, id);
            check("fwd_m_bready", m_axi_bready, 1'b1);
            @(negedge uncoreclk);
            m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
            #1;
            check("wr_back_idle", s_axi_awready, 1'b1);
            check("fwd_bvalid_end", s_axi_bvalid, 1'b0);
        end else begin
            check("miss_no_m_awvalid", m_axi_awvalid, 1'b0);
            m_axi_wready = 1'b0;
            for (int i = 0; i < beats; i++) begin
                s_axi_wvalid = 1'b1; s_axi_wdata = 64'(i); s_axi_wlast = (i == beats - 1);
                #1;
                check("sink_wready", s_axi_wready, 1'b1);
                check("sink_no_m_wvalid", m_axi_wvalid, 1'b0);
                @(negedge uncoreclk);
            end
            s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
            #1;
            check("err_bvalid", s_axi_bvalid, 1'b1);
            check("err_bresp", s_axi_bresp, 2'b11);
            check("err_bid", s_axi_bid, id);
            check("err_m_awvalid", m_axi_awvalid, 1'b0);
            @(negedge uncoreclk);
            #1 check("err_bvalid_held", s_axi_bvalid, 1'b1);
            s_axi_bready = 1'b1;
            @(negedge uncoreclk);
            s_axi_bready = 1'b0;
            #1;
            check("err_bvalid_end", s_axi_bvalid, 1'b0);
            check("err_wr_idle", s_axi_awready, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            wr    addr           len    size  rnd  dly hit   maddr
        vecs[0]  = '{1'b0, 32'h8000_1000, 8'd3,   3'd3, 1'b0, 0, 1'b1, 32'h1000_1000};
        vecs[1]  = '{1'b0, 32'h4000_0000, 8'd7,   3'd3, 1'b1, 0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h9000_0000, 8'd3,   3'd3, 1'b0, 0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h8FFF_FFF0, 8'd3,   3'd3, 1'b0, 0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h8FFF_FFE0, 8'd3,   3'd3, 1'b0, 1, 1'b1, 32'h1FFF_FFE0};
        vecs[5]  = '{1'b0, 32'h7FFF_FFF8, 8'd0,   3'd3, 1'b0, 0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h8FFF_FFF8, 8'd0,   3'd3, 1'b0, 0, 1'b1, 32'h1FFF_FFF8};
        vecs[7]  = '{1'b0, 32'hFFFF_FFF0, 8'd3,   3'd3, 1'b0, 0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h8000_0000, 8'd0,   3'd2, 1'b0, 3, 1'b1, 32'h1000_0000};
        vecs[9]  = '{1'b0, 32'h8FFF_FF00, 8'd255, 3'd0, 1'b0, 0, 1'b1, 32'h1FFF_FF00};
        vecs[10] = '{1'b0, 32'h0000_0000, 8'd255, 3'd3, 1'b1, 0, 1'b0, 32'h0};

        // Reset state
        #2 uncore_rstn = 1'b0;
        repeat (3) @(negedge uncoreclk);
        #1;
        check("rst_s_bvalid", s_axi_bvalid, 1'b0);
        check("rst_s_rvalid", s_axi_rvalid, 1'b0);
        check("rst_m_awvalid", m_axi_awvalid, 1'b0);
        check("rst_m_arvalid", m_axi_arvalid, 1'b0);
        check("rst_bresp", s_axi_bresp, 2'b00);
        check("rst_rresp", s_axi_rresp, 2'b00);
        check("rst_rlast", s_axi_rlast, 1'b0);
        check("rst_rdata", s_axi_rdata, 64'd0);
        @(negedge uncoreclk);
        uncore_rstn = 1'b1;
        #1;
        check("idle_awready", s_axi_awready, 1'b1);
        check("idle_arready", s_axi_arready, 1'b1);

        // Vector table
        for (int k = 0; k < 11; k++) begin
            if (vecs[k].wr) do_write(vecs[k], 1'(k));
            else            do_read(vecs[k], 1'(k));
        end

        // Reset in the middle of a DECERR read burst
        @(negedge uncoreclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h4000_0000; s_axi_arlen = 8'd7;
        s_axi_arsize = 3'd3; s_axi_arid = 1'b1;
        @(negedge uncoreclk);
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        #1 check("rst_burst_beat1", s_axi_rvalid, 1'b1);
        @(negedge uncoreclk);
        s_axi_rready = 1'b0;
        #1;
        check("rst_burst_beat2_valid", s_axi_rvalid, 1'b1);
        check("rst_burst_beat2_rlast", s_axi_rlast, 1'b0);
        uncore_rstn = 1'b0;
        #1;
        check("rst_async_rvalid", s_axi_rvalid, 1'b0);
        check("rst_async_rresp", s_axi_rresp, 2'b00);
        repeat (2) @(negedge uncoreclk);
        uncore_rstn = 1'b1;
        #1 check("rst_release_rvalid", s_axi_rvalid, 1'b0);
        @(negedge uncoreclk);
        #1 check("rst_release_rvalid_2", s_axi_rvalid, 1'b0);
        do_read(vecs[0], 1'b1);

`ifdef AXI_MEM_WINDOW_ERRCNT_EN
        check("errcnt_after_rst", err_cnt, 16'd0);
        v = '{1'b0, 32'h1000_0000, 8'd0, 3'd3, 1'b0, 0, 1'b0, 32'h0};
        do_read(v, 1'b0);
        v.addr = 32'h9000_0000;
        do_read(v, 1'b0);
        v.addr = 32'hA000_0040;
        do_read(v, 1'b0);
        check("errcnt_three", err_cnt, 16'd3);
        check("erraddr_last", err_addr, 32'hA000_0040);
`endif

        // Same-cycle AW and AR, both rejected
        @(negedge uncoreclk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h9000_0000; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd3; s_axi_awid = 1'b1;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h4000_0000; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd3; s_axi_arid = 1'b0;
        #1;
        check("dual_awready", s_axi_awready, 1'b1);
        check("dual_arready", s_axi_arready, 1'b1);
        @(negedge uncoreclk);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        #1;
        check("dual_rvalid", s_axi_rvalid, 1'b1);
        check("dual_rresp", s_axi_rresp, 2'b11);
        check("dual_rlast", s_axi_rlast, 1'b1);
        check("dual_no_m_awvalid", m_axi_awvalid, 1'b0);
        check("dual_no_m_arvalid", m_axi_arvalid, 1'b0);
        s_axi_rready = 1'b1; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
        #1 check("dual_sink_wready", s_axi_wready, 1'b1);
        @(negedge uncoreclk);
        s_axi_rready = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        #1;
        check("dual_rvalid_end", s_axi_rvalid, 1'b0);
        check("dual_bvalid", s_axi_bvalid, 1'b1);
        check("dual_bresp", s_axi_bresp, 2'b11);
        check("dual_bid", s_axi_bid, 1'b1);
        s_axi_bready = 1'b1;
        @(negedge uncoreclk);
        s_axi_bready = 1'b0;
        #1 check("dual_bvalid_end", s_axi_bvalid, 1'b0);

`ifdef AXI_MEM_WINDOW_ERRCNT_EN
        check("errcnt_dual", err_cnt, 16'd5);
        check("erraddr_dual_ar", err_addr, 32'h4000_0000);
        force dut.err_cnt = 16'hFFFE;
        @(negedge uncoreclk);
        release dut.err_cnt;
        v = '{1'b0, 32'h0000_1000, 8'd0, 3'd3, 1'b0, 0, 1'b0, 32'h0};
        do_read(v, 1'b0);
        v.addr = 32'h0000_2000;
        do_read(v, 1'b0);
        check("errcnt_saturate", err_cnt, 16'hFFFF);
`endif

        repeat (2) @(negedge uncoreclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
